tmr_voter_monitor: RTL and testbench

//  Registered triple-modular-redundancy word voter with per-lane health tracking.

---
 rtl/seu_voter_pkg.sv | 22 ++
 rtl/tmr_voter_lane_fsm.sv | 82 ++++++++
 rtl/tmr_voter_monitor.sv | 167 ++++++++++++++++
 tb/tb_tmr_voter_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seu_voter_pkg.sv
// Shared types and helpers for the TMR word voter and its per-lane health FSMs.
package seu_voter_pkg;

    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        RETIRED = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic                 err1;
        logic                 err2;
        logic [NUM_LANES-1:0] lane_err;
    } vote_status_t;

    function automatic logic [1:0] count_retired(input logic [NUM_LANES-1:0] retired);
        count_retired = {1'b0, retired[0]} + {1'b0, retired[1]} + {1'b0, retired[2]};
    endfunction

endpackage

// File: rtl/tmr_voter_lane_fsm.sv
// Health tracker for one redundant lane: counts consecutive attributed mismatches
// and retires the lane once the run reaches FAULT_THRESH.
module tmr_voter_lane_fsm
    import seu_voter_pkg::*;
#(
    parameter int CNT_WIDTH    = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid,
    input  logic        attributed,
    input  logic        unattrib_err2,
    input  logic        clear,
    output lane_state_e state,
    output logic        retired
);

    localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(FAULT_THRESH);
    localparam logic [CNT_WIDTH-1:0] RUN_ONE = CNT_WIDTH'(1);

    lane_state_e          state_r;
    lane_state_e          state_s;
    logic [CNT_WIDTH-1:0] run_r;
    logic [CNT_WIDTH-1:0] run_s;

    // State and run-length registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= HEALTHY;
            run_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            run_r   <= run_s;
        end
    end

    // Next-state logic; clear overrides any update from a coincident sample.
    always_comb begin
        state_s = state_r;
        run_s   = run_r;
        if (clear) begin
            state_s = HEALTHY;
            run_s   = {CNT_WIDTH{1'b0}};
        end else if (valid) begin
            case (state_r)
                HEALTHY: begin
                    if (attributed) begin
                        run_s   = RUN_ONE;
                        state_s = (RUN_ONE >= THRESH) ? RETIRED : SUSPECT;
                    end else begin
                        state_s = HEALTHY;
                    end
                end
                SUSPECT: begin
                    if (attributed) begin
                        run_s   = run_r + RUN_ONE;
                        state_s = ((run_r + RUN_ONE) >= THRESH) ? RETIRED : SUSPECT;
                    end else if (!unattrib_err2) begin
                        state_s = HEALTHY;
                        run_s   = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_s = SUSPECT;
                    end
                end
                RETIRED: begin
                    state_s = RETIRED;
                end
                default: begin
                    state_s = HEALTHY;
                    run_s   = {CNT_WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign state   = state_r;
    assign retired = (state_r == RETIRED);

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered TMR word voter with per-lane health tracking and degraded 2-lane mode.
// Define TMR_VOTER_CNT_EN to build the saturating error1/error2 event counters.
module tmr_voter_monitor
    import seu_voter_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int CNT_WIDTH    = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [IN_WIDTH-1:0]  in0_i,
    input  logic [IN_WIDTH-1:0]  in1_i,
    input  logic [IN_WIDTH-1:0]  in2_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output logic [IN_WIDTH-1:0]  out_o,
    output logic                 error1_o,
    output logic                 error2_o,
    output logic [2:0]           lane_err_o,
    output logic [2:0]           lane_faulty_o,
    output logic [CNT_WIDTH-1:0] err1_cnt_o,
    output logic [CNT_WIDTH-1:0] err2_cnt_o
);

    lane_state_e          lane_state_s [NUM_LANES];
    logic [NUM_LANES-1:0] retired_s;
    vote_status_t         vote_s;
    logic [IN_WIDTH-1:0]  vote_word_s;
    logic [IN_WIDTH-1:0]  pair_a_s;
    logic [IN_WIDTH-1:0]  pair_b_s;
    logic                 eq01_s;
    logic                 eq02_s;
    logic                 eq12_s;

    assign eq01_s = (in0_i == in1_i);
    assign eq02_s = (in0_i == in2_i);
    assign eq12_s = (in1_i == in2_i);

    // Majority vote over the lanes that are not retired at the time of the sample.
    always_comb begin
        vote_word_s     = in0_i;
        vote_s.err1     = 1'b0;
        vote_s.err2     = 1'b0;
        vote_s.lane_err = 3'b000;
        pair_a_s        = in0_i;
        pair_b_s        = in1_i;
        case (count_retired(retired_s))
            2'd0: begin
                if (eq01_s && eq02_s) begin
                    vote_word_s = in0_i;
                end else if (eq01_s) begin
                    vote_s.err1     = 1'b1;
                    vote_s.lane_err = 3'b100;
                end else if (eq02_s) begin
                    vote_s.err1     = 1'b1;
                    vote_s.lane_err = 3'b010;
                end else if (eq12_s) begin
                    vote_word_s     = in1_i;
                    vote_s.err1     = 1'b1;
                    vote_s.lane_err = 3'b001;
                end else begin
                    vote_s.err1 = 1'b1;
                    vote_s.err2 = 1'b1;
                end
            end
            2'd1: begin
                if (retired_s[0]) begin
                    pair_a_s = in1_i;
                    pair_b_s = in2_i;
                end else if (retired_s[1]) begin
                    pair_a_s = in0_i;
                    pair_b_s = in2_i;
                end else begin
                    pair_a_s = in0_i;
                    pair_b_s = in1_i;
                end
                vote_word_s = pair_a_s;
                if (pair_a_s != pair_b_s) begin
                    vote_s.err1 = 1'b1;
                    vote_s.err2 = 1'b1;
                end else begin
                    vote_s.err1 = 1'b0;
                end
            end
            default: begin
                vote_s.err2 = 1'b1;
                if (!retired_s[0]) begin
                    vote_word_s = in0_i;
                end else if (!retired_s[1]) begin
                    vote_word_s = in1_i;
                end else if (!retired_s[2]) begin
                    vote_word_s = in2_i;
                end else begin
                    vote_word_s = in0_i;
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        tmr_voter_lane_fsm #(
            .CNT_WIDTH    (CNT_WIDTH),
            .FAULT_THRESH (FAULT_THRESH)
        ) u_lane (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .valid         (valid_i),
            .attributed    (vote_s.lane_err[gi]),
            .unattrib_err2 (vote_s.err2),
            .clear         (clear_i),
            .state         (lane_state_s[gi]),
            .retired       (retired_s[gi])
        );
        assign lane_faulty_o[gi] = (lane_state_s[gi] == RETIRED);
    end

    // Output and status registers; data fields load only with a valid sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            out_o      <= {IN_WIDTH{1'b0}};
            error1_o   <= 1'b0;
            error2_o   <= 1'b0;
            lane_err_o <= 3'b000;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                out_o      <= vote_word_s;
                error1_o   <= vote_s.err1;
                error2_o   <= vote_s.err2;
                lane_err_o <= vote_s.lane_err;
            end
        end
    end

`ifdef TMR_VOTER_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] err1_cnt_r;
    logic [CNT_WIDTH-1:0] err2_cnt_r;

    // Saturating event counters; clear beats a coincident increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err1_cnt_r <= {CNT_WIDTH{1'b0}};
            err2_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (valid_i) begin
            if (vote_s.err1 && (err1_cnt_r != CNT_MAX)) begin
                err1_cnt_r <= err1_cnt_r + CNT_ONE;
            end
            if (vote_s.err2 && (err2_cnt_r != CNT_MAX)) begin
                err2_cnt_r <= err2_cnt_r + CNT_ONE;
            end
        end
    end

    assign err1_cnt_o = err1_cnt_r;
    assign err2_cnt_o = err2_cnt_r;
`else
    assign err1_cnt_o = {CNT_WIDTH{1'b0}};
    assign err2_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Self-checking bench for tmr_voter_monitor: a default instance and a
// CNT_WIDTH=2 / FAULT_THRESH=1 instance share stimulus and a behavioural model.
module tb_tmr_voter_monitor;

`ifdef TMR_VOTER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        clr;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;

    logic        a_valid, a_e1, a_e2;
    logic [31:0] a_out;
    logic [2:0]  a_le, a_lf;
    logic [7:0]  a_c1, a_c2;
    logic        b_valid, b_e1, b_e2;
    logic [31:0] b_out;
    logic [2:0]  b_le, b_lf;
    logic [1:0]  b_c1, b_c2;

    tmr_voter_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .in0_i(in0), .in1_i(in1), .in2_i(in2),
        .clear_i(clr), .valid_o(a_valid), .out_o(a_out), .error1_o(a_e1), .error2_o(a_e2),
        .lane_err_o(a_le), .lane_faulty_o(a_lf), .err1_cnt_o(a_c1), .err2_cnt_o(a_c2)
    );

    tmr_voter_monitor #(.IN_WIDTH(32), .CNT_WIDTH(2), .FAULT_THRESH(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .in0_i(in0), .in1_i(in1), .in2_i(in2),
        .clear_i(clr), .valid_o(b_valid), .out_o(b_out), .error1_o(b_e1), .error2_o(b_e2),
        .lane_err_o(b_le), .lane_faulty_o(b_lf), .err1_cnt_o(b_c1), .err2_cnt_o(b_c2)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state, index 0 = u_dut, 1 = u_sat.
    int          THR  [2] = '{4, 1};
    int          CMAX [2] = '{255, 3};
    int          m_run[2][3];
    bit          m_ret[2][3];
    int          m_c1 [2];
    int          m_c2 [2];
    logic [31:0] e_out[2];
    logic        e_e1 [2];
    logic        e_e2 [2];
    logic [2:0]  e_le [2];
    logic        e_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input int k);
        for (int i = 0; i < 3; i++) begin
            m_run[k][i] = 0;
            m_ret[k][i] = 1'b0;
        end
        m_c1[k] = 0;
        m_c2[k] = 0;
    endfunction

    // Vote computed from the rules: agreement counts among the non-retired lanes.
    function automatic void model_vote(input int k, input logic [31:0] w0, w1, w2,
                                       output logic [31:0] o, output logic e1, e2,
                                       output logic [2:0] le);
        logic [31:0] w [3];
        int          h [$];
        int          agree [3];
        int          maj;
        w  = '{w0, w1, w2};
        e1 = 1'b0;
        e2 = 1'b0;
        le = 3'b000;
        o  = w0;
        for (int i = 0; i < 3; i++) if (!m_ret[k][i]) h.push_back(i);
        if (h.size() == 3) begin
            maj = -1;
            for (int i = 0; i < 3; i++) begin
                agree[i] = 0;
                for (int j = 0; j < 3; j++) if (j != i && w[j] == w[i]) agree[i]++;
            end
            for (int i = 2; i >= 0; i--) if (agree[i] >= 1) maj = i;
            if (maj < 0) begin
                e1 = 1'b1;
                e2 = 1'b1;
            end else begin
                o = w[maj];
                for (int i = 0; i < 3; i++) begin
                    if (agree[i] == 0) begin
                        le[i] = 1'b1;
                        e1    = 1'b1;
                    end
                end
            end
        end else if (h.size() == 2) begin
            o = w[h[0]];
            if (w[h[0]] != w[h[1]]) begin
                e1 = 1'b1;
                e2 = 1'b1;
            end
        end else begin
            e2 = 1'b1;
            o  = (h.size() == 1) ? w[h[0]] : w0;
        end
    endfunction

    task automatic check_all();
        check("a.valid_o", 32'(a_valid), 32'(e_v));
        check("a.out_o", a_out, e_out[0]);
        check("a.error1_o", 32'(a_e1), 32'(e_e1[0]));
        check("a.error2_o", 32'(a_e2), 32'(e_e2[0]));
        check("a.lane_err_o", 32'(a_le), 32'(e_le[0]));
        check("a.lane_faulty_o", 32'(a_lf), 32'({m_ret[0][2], m_ret[0][1], m_ret[0][0]}));
        check("a.err1_cnt_o", 32'(a_c1), CNT_EN ? 32'(m_c1[0]) : 32'd0);
        check("a.err2_cnt_o", 32'(a_c2), CNT_EN ? 32'(m_c2[0]) : 32'd0);
        check("b.valid_o", 32'(b_valid), 32'(e_v));
        check("b.out_o", b_out, e_out[1]);
        check("b.error1_o", 32'(b_e1), 32'(e_e1[1]));
        check("b.error2_o", 32'(b_e2), 32'(e_e2[1]));
        check("b.lane_err_o", 32'(b_le), 32'(e_le[1]));
        check("b.lane_faulty_o", 32'(b_lf), 32'({m_ret[1][2], m_ret[1][1], m_ret[1][0]}));
        check("b.err1_cnt_o", 32'(b_c1), CNT_EN ? 32'(m_c1[1]) : 32'd0);
        check("b.err2_cnt_o", 32'(b_c2), CNT_EN ? 32'(m_c2[1]) : 32'd0);
    endtask

    // One clock of stimulus, then update the model and compare every output.
    task automatic step(input logic v, input logic [31:0] a, b, c,
                        input logic clr_v, input logic rs);
        logic [31:0] o;
        logic        e1, e2;
        logic [2:0]  le;
        valid = v; in0 = a; in1 = b; in2 = c; clr = clr_v; rst = rs;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                model_reset(k);
                e_out[k] = 32'd0; e_e1[k] = 1'b0; e_e2[k] = 1'b0; e_le[k] = 3'b000;
            end else begin
                if (v) begin
                    model_vote(k, a, b, c, o, e1, e2, le);
                    e_out[k] = o; e_e1[k] = e1; e_e2[k] = e2; e_le[k] = le;
                    for (int i = 0; i < 3; i++) begin
                        if (le[i]) begin
                            m_run[k][i]++;
                            if (m_run[k][i] >= THR[k]) m_ret[k][i] = 1'b1;
                        end else if (!e2) begin
                            m_run[k][i] = 0;
                        end
                    end
                    if (e1 && m_c1[k] < CMAX[k]) m_c1[k]++;
                    if (e2 && m_c2[k] < CMAX[k]) m_c2[k]++;
                end
                if (clr_v) model_reset(k);
            end
        end
        e_v = rs ? 1'b0 : v;
        check_all();
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] w [3];
        int          kind;
        int          tgt;
        valid = 1'b0; clr = 1'b0; rst = 1'b1;
        in0 = 32'd0; in1 = 32'd0; in2 = 32'd0;

        // Reset state.
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // All lanes equal.
        for (int n = 0; n < 10; n++) step(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Lane 1 wrong three times, then clean: SUSPECT then back to HEALTHY.
        for (int n = 0; n < 3; n++) step(1'b1, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Lane 2 wrong four times -> retired, then degraded 2-lane disagreement.
        for (int n = 0; n < 4; n++) step(1'b1, 32'h7, 32'h7, 32'h9, 1'b0, 1'b0);
        step(1'b1, 32'h5, 32'h6, 32'h5, 1'b0, 1'b0);

        // Clear, then all lanes differ.
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);

        // Five error1 samples rotating the bad lane; the 2-bit counters saturate.
        for (int n = 0; n < 5; n++) begin
            tgt = n % 3;
            step(1'b1, (tgt == 0) ? 32'h4 : 32'h3, (tgt == 1) ? 32'h4 : 32'h3,
                 (tgt == 2) ? 32'h4 : 32'h3, 1'b0, 1'b0);
        end

        // Retire lane 0, then clear together with a 2-lane sample.
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) step(1'b1, 32'h9, 32'h2, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h9, 32'h7, 32'h8, 1'b1, 1'b0);
        step(1'b1, 32'h2, 32'h2, 32'h2, 1'b0, 1'b0);

        // Reset in the middle of a stream.
        step(1'b1, 32'h3, 32'h3, 32'h3, 1'b0, 1'b0);
        step(1'b1, 32'h4, 32'h4, 32'h4, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic with a slowly rotating preferred faulty lane.
        for (int n = 0; n < 600; n++) begin
            base = $urandom;
            kind = $urandom_range(0, 9);
            tgt  = (kind < 6) ? (n / 80) % 3 : $urandom_range(0, 2);
            w    = '{base, base, base};
            if (kind < 8) w[tgt] = base ^ (32'h1 << $urandom_range(0, 31));
            if (kind == 8) w = '{base, base ^ 32'h1, base ^ 32'h2};
            if (kind == 9 && $urandom_range(0, 1) == 1) w[tgt] = base;
            step(($urandom_range(0, 3) != 0), w[0], w[1], w[2],
                 ($urandom_range(0, 60) == 0), ($urandom_range(0, 200) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
